// File: rtl/decoder_pipe_stage.sv
// rtl/decoder_pipe_stage.sv - registered SIMD decode stage with valid/ready handshakes
// and a scalar/vector busy-bit scoreboard that stalls issue on RAW/WAW hazards.
module decoder_pipe_stage #(
  parameter int INSTR_W = 24,
  parameter int REG_W   = 4,
  parameter int IMM_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               InValid,
  output logic               InReady,
  input  logic [INSTR_W-1:0] instruction,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [2:0]         PcWriteEn,
  output logic               MemoryWrite,
  output logic [1:0]         WriteRegFrom,
  output logic [REG_W-1:0]   RegToWrite,
  output logic [IMM_W-1:0]   Immediate,
  output logic               writeMemFrom,
  output logic               RegWriteEnSc,
  output logic               RegWriteEnVec,
  output logic               OverWriteNz,
  output logic [2:0]         AluOpCode,
  output logic [REG_W-1:0]   Rs1,
  output logic [REG_W-1:0]   Rs2,
  output logic               IllegalOp,
  input  logic               Flush,
  input  logic               WbValid,
  input  logic               WbVec,
  input  logic [REG_W-1:0]   WbReg
);

  localparam int NREG = 1 << REG_W;

  typedef struct packed {
    logic [2:0]       pc;
    logic             mem_wr;
    logic [1:0]       wr_from;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
    logic             mem_from;
    logic             we_sc;
    logic             we_vec;
    logic             nz;
    logic [2:0]       alu;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } bundle_t;

  bundle_t          bundle_d, bundle_q;
  logic             valid_d, valid_q;
  logic             illegal_d, illegal_q;
  logic [NREG-1:0]  busy_sc_d, busy_sc_q, busy_vec_d, busy_vec_q;
  logic [NREG-1:0]  hz_sc, hz_vec;

  logic [3:0]       op;
  logic             v;
  logic [REG_W-1:0] f_rd, f_rs1, f_rs2;
  logic             use_rs1, use_rs2, use_rd, rs1_vec;
  logic             hazard, in_xfer, out_xfer;

  assign op    = instruction[INSTR_W-1 -: 4];
  assign v     = instruction[INSTR_W-5];
  assign f_rd  = instruction[INSTR_W-6 -: REG_W];
  assign f_rs1 = instruction[INSTR_W-6-REG_W -: REG_W];
  assign f_rs2 = instruction[INSTR_W-6-2*REG_W -: REG_W];

  always_comb begin
    bundle_d  = '0;
    illegal_d = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    use_rd    = 1'b0;
    rs1_vec   = 1'b0;
    case (op)
      4'b0000: begin
        bundle_d.we_sc   = !v;
        bundle_d.we_vec  = v;
        bundle_d.wr_from = 2'b10;
        bundle_d.rd      = f_rd;
        bundle_d.imm     = instruction[IMM_W-1:0];
        use_rd           = 1'b1;
      end
      4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111: begin
        bundle_d.nz     = 1'b1;
        bundle_d.we_sc  = !v;
        bundle_d.we_vec = v;
        bundle_d.rd     = f_rd;
        bundle_d.rs1    = f_rs1;
        use_rd          = 1'b1;
        use_rs1         = 1'b1;
        rs1_vec         = v;
        if (op != 4'b0111) begin
          bundle_d.rs2 = f_rs2;
          use_rs2      = 1'b1;
        end
        case (op)
          4'b0010: bundle_d.alu = 3'b000;
          4'b0011: bundle_d.alu = 3'b001;
          4'b0001: bundle_d.alu = 3'b010;
          4'b0100: bundle_d.alu = 3'b011;
          4'b0101: bundle_d.alu = 3'b100;
          4'b0110: bundle_d.alu = 3'b101;
          default: bundle_d.alu = 3'b110;
        endcase
      end
      4'b1000, 4'b1001, 4'b1010: begin
        bundle_d.pc  = (op == 4'b1000) ? 3'b001 : (op == 4'b1001) ? 3'b010 : 3'b100;
        bundle_d.imm = instruction[IMM_W-1:0];
      end
      4'b1101, 4'b1111: begin
        bundle_d.wr_from = 2'b01;
        bundle_d.we_sc   = !v;
        bundle_d.we_vec  = v;
        bundle_d.rd      = f_rd;
        bundle_d.rs1     = f_rs1;
        use_rd           = 1'b1;
        use_rs1          = 1'b1;
      end
      4'b1110: begin
        // the store-data register (rd) is presented to execute on Rs2
        bundle_d.mem_wr   = 1'b1;
        bundle_d.mem_from = v;
        bundle_d.rs1      = f_rs1;
        bundle_d.rs2      = f_rd;
        use_rs1           = 1'b1;
        use_rd            = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // a register hazards if busy without a same-cycle write-back, or if the held bundle writes it
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      hz_sc[r]  = (busy_sc_q[r] & !(WbValid & !WbVec & (WbReg == REG_W'(r))))
                | (valid_q & bundle_q.we_sc & (bundle_q.rd == REG_W'(r)));
      hz_vec[r] = (busy_vec_q[r] & !(WbValid & WbVec & (WbReg == REG_W'(r))))
                | (valid_q & bundle_q.we_vec & (bundle_q.rd == REG_W'(r)));
    end
  end

  assign hazard = (use_rs1 & (rs1_vec ? hz_vec[f_rs1] : hz_sc[f_rs1]))
                | (use_rs2 & (v ? hz_vec[f_rs2] : hz_sc[f_rs2]))
                | (use_rd  & (v ? hz_vec[f_rd]  : hz_sc[f_rd]));

  assign InReady  = !hazard & (!valid_q | OutReady) & !Flush;
  assign in_xfer  = InValid & InReady;
  assign out_xfer = valid_q & OutReady & !Flush;

  always_comb begin
    valid_d    = valid_q;
    busy_sc_d  = busy_sc_q;
    busy_vec_d = busy_vec_q;
    if (in_xfer)               valid_d = 1'b1;
    else if (Flush | out_xfer) valid_d = 1'b0;
    if (WbValid) begin
      if (WbVec) busy_vec_d[WbReg] = 1'b0;
      else       busy_sc_d[WbReg]  = 1'b0;
    end
    if (out_xfer & bundle_q.we_sc)  busy_sc_d[bundle_q.rd]  = 1'b1;
    if (out_xfer & bundle_q.we_vec) busy_vec_d[bundle_q.rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      bundle_q   <= '0;
      illegal_q  <= 1'b0;
      busy_sc_q  <= '0;
      busy_vec_q <= '0;
    end else begin
      valid_q    <= valid_d;
      illegal_q  <= in_xfer & illegal_d;
      busy_sc_q  <= busy_sc_d;
      busy_vec_q <= busy_vec_d;
      if (in_xfer) bundle_q <= bundle_d;
    end
  end

  assign OutValid      = valid_q;
  assign IllegalOp     = illegal_q;
  assign PcWriteEn     = bundle_q.pc;
  assign MemoryWrite   = bundle_q.mem_wr;
  assign WriteRegFrom  = bundle_q.wr_from;
  assign RegToWrite    = bundle_q.rd;
  assign Immediate     = bundle_q.imm;
  assign writeMemFrom  = bundle_q.mem_from;
  assign RegWriteEnSc  = bundle_q.we_sc;
  assign RegWriteEnVec = bundle_q.we_vec;
  assign OverWriteNz   = bundle_q.nz;
  assign AluOpCode     = bundle_q.alu;
  assign Rs1           = bundle_q.rs1;
  assign Rs2           = bundle_q.rs2;

endmodule

// File: tb/tb_decoder_pipe_stage.sv
// tb/tb_decoder_pipe_stage.sv - directed and random checks of decoder_pipe_stage
// against a transaction-level reference model.
module tb_decoder_pipe_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [23:0] instr;
  logic [2:0]  pc_we, alu_op;
  logic        mem_wr, wmem_from, we_sc, we_vec, ow_nz, illegal;
  logic [1:0]  wr_from;
  logic [3:0]  reg_to_write, rs1, rs2, wb_reg;
  logic [15:0] imm;
  logic        flush, wb_valid, wb_vec;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decoder_pipe_stage dut (
    .clk(clk), .rst_n(rst_n), .InValid(in_valid), .InReady(in_ready),
    .instruction(instr), .OutValid(out_valid), .OutReady(out_ready),
    .PcWriteEn(pc_we), .MemoryWrite(mem_wr), .WriteRegFrom(wr_from),
    .RegToWrite(reg_to_write), .Immediate(imm), .writeMemFrom(wmem_from),
    .RegWriteEnSc(we_sc), .RegWriteEnVec(we_vec), .OverWriteNz(ow_nz),
    .AluOpCode(alu_op), .Rs1(rs1), .Rs2(rs2), .IllegalOp(illegal),
    .Flush(flush), .WbValid(wb_valid), .WbVec(wb_vec), .WbReg(wb_reg)
  );

  typedef struct packed {
    logic [2:0]  pc;
    logic        mw;
    logic [1:0]  wrf;
    logic [3:0]  rtw;
    logic [15:0] imm;
    logic        wmf, wsc, wvec, nz;
    logic [2:0]  alu;
    logic [3:0]  rs1, rs2;
    logic        ill;
    logic [2:0]  acc_en;
    logic [2:0]  acc_vec;
    logic [11:0] acc_reg;
  } dec_t;

  dec_t m_held;
  bit   m_valid, m_ill;
  bit   m_busy [2][16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] enc(input logic [3:0] op, input logic v,
                                      input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb);
    return {op, v, rd, ra, rb, 7'h00};
  endfunction

  function automatic dec_t ref_decode(input logic [23:0] ins);
    dec_t d = '0;
    int   k = 0;
    logic [3:0] op = ins[23:20];
    logic v = ins[19];
    logic [3:0] rd = ins[18:15], ra = ins[14:11], rb = ins[10:7];
    logic [2:0] alu_tbl [8] = '{3'b000, 3'b010, 3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110};
    if (op == 4'd0) begin
      d.wsc = !v; d.wvec = v; d.wrf = 2'b10; d.rtw = rd; d.imm = ins[15:0];
      d.acc_en[0] = 1; d.acc_vec[0] = v; d.acc_reg[3:0] = rd;
    end else if (op <= 4'd7) begin
      d.wsc = !v; d.wvec = v; d.nz = 1; d.rtw = rd; d.rs1 = ra; d.alu = alu_tbl[op[2:0]];
      d.acc_en[0] = 1; d.acc_vec[0] = v; d.acc_reg[3:0] = rd;
      d.acc_en[1] = 1; d.acc_vec[1] = v; d.acc_reg[7:4] = ra;
      if (op != 4'd7) begin
        d.rs2 = rb; d.acc_en[2] = 1; d.acc_vec[2] = v; d.acc_reg[11:8] = rb;
      end
    end else if (op <= 4'd10) begin
      d.pc = 3'b001 << (op - 4'd8); d.imm = ins[15:0];
    end else if (op == 4'd13 || op == 4'd15) begin
      d.wrf = 2'b01; d.wsc = !v; d.wvec = v; d.rtw = rd; d.rs1 = ra;
      d.acc_en[0] = 1; d.acc_vec[0] = v; d.acc_reg[3:0] = rd;
      d.acc_en[1] = 1; d.acc_vec[1] = 0; d.acc_reg[7:4] = ra;
    end else if (op == 4'd14) begin
      d.mw = 1; d.wmf = v; d.rs1 = ra; d.rs2 = rd;
      d.acc_en[0] = 1; d.acc_vec[0] = v; d.acc_reg[3:0] = rd;
      d.acc_en[1] = 1; d.acc_vec[1] = 0; d.acc_reg[7:4] = ra;
    end else begin
      d.ill = 1;
    end
    k = 0;
    return d;
  endfunction

  function automatic bit model_hazard(input dec_t d);
    bit h = 0;
    for (int k = 0; k < 3; k++) begin
      if (d.acc_en[k]) begin
        logic       f = d.acc_vec[k];
        logic [3:0] r = d.acc_reg[k*4 +: 4];
        bit wb_hit = wb_valid && (wb_vec == f) && (wb_reg == r);
        bit held_w = m_valid && (f ? m_held.wvec : m_held.wsc) && (m_held.rtw == r);
        if ((m_busy[f][r] && !wb_hit) || held_w) h = 1;
      end
    end
    return h;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_ill = 0; m_held = '0;
    for (int f = 0; f < 2; f++) for (int r = 0; r < 16; r++) m_busy[f][r] = 0;
  endtask

  task automatic check_outputs(input bit exp_rdy);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, m_valid);
    check("illegal_op", illegal, m_ill);
    check("pc_write_en", pc_we, m_held.pc);
    check("memory_write", mem_wr, m_held.mw);
    check("write_reg_from", wr_from, m_held.wrf);
    check("reg_to_write", reg_to_write, m_held.rtw);
    check("immediate", imm, m_held.imm);
    check("write_mem_from", wmem_from, m_held.wmf);
    check("we_sc", we_sc, m_held.wsc);
    check("we_vec", we_vec, m_held.wvec);
    check("overwrite_nz", ow_nz, m_held.nz);
    check("alu_opcode", alu_op, m_held.alu);
    check("rs1", rs1, m_held.rs1);
    check("rs2", rs2, m_held.rs2);
  endtask

  task automatic cycle();
    dec_t d;
    bit exp_rdy, in_x, out_x;
    @(negedge clk);
    d = ref_decode(instr);
    exp_rdy = !model_hazard(d) && (!m_valid || out_ready) && !flush;
    check_outputs(exp_rdy);
    in_x  = in_valid && exp_rdy;
    out_x = m_valid && out_ready && !flush;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (wb_valid) m_busy[wb_vec][wb_reg] = 0;
      if (out_x && (m_held.wsc || m_held.wvec)) m_busy[m_held.wvec][m_held.rtw] = 1;
      m_ill = in_x && d.ill;
      if (in_x) begin
        m_held = d; m_valid = 1;
      end else if (flush || out_x) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; instr = '0; out_ready = 1;
    flush = 0; wb_valid = 0; wb_vec = 0; wb_reg = '0;
    model_reset();
    repeat (2) cycle();
    rst_n = 1;
    cycle();

    in_valid = 1; instr = 24'h070002;
    cycle();
    in_valid = 0; cycle();

    in_valid = 1;
    instr = 24'hA05015; cycle();
    instr = 24'h804010; cycle();
    instr = 24'h904032; cycle();
    in_valid = 0; repeat (2) cycle();

    in_valid = 1; instr = enc(4'd2, 0, 4'd1, 4'd2, 4'd3); cycle();
    instr = enc(4'd1, 0, 4'd4, 4'd1, 4'd5);
    repeat (3) cycle();
    wb_valid = 1; wb_vec = 0; wb_reg = 4'd1;
    cycle();
    wb_valid = 0; in_valid = 0; cycle();

    in_valid = 1; instr = enc(4'd4, 1, 4'd6, 4'd7, 4'd8); cycle();
    out_ready = 0; instr = enc(4'd3, 0, 4'd9, 4'd10, 4'd11);
    repeat (3) cycle();
    out_ready = 1; cycle();
    in_valid = 0; cycle();

    in_valid = 1; instr = enc(4'd0, 0, 4'd12, 4'd0, 4'd0); out_ready = 0; cycle();
    in_valid = 0; flush = 1; cycle();
    flush = 0; out_ready = 1; cycle();
    in_valid = 1; cycle();
    in_valid = 0; cycle();

    in_valid = 1; instr = 24'hB00000; cycle();
    in_valid = 0; repeat (2) cycle();

    in_valid = 1; instr = enc(4'd2, 1, 4'd2, 4'd3, 4'd4); cycle();
    instr = enc(4'd7, 1, 4'd5, 4'd2, 4'd0);
    repeat (3) cycle();
    rst_n = 0; #1;
    model_reset();
    check_outputs(1'b1);
    cycle();
    rst_n = 1; cycle();
    in_valid = 0; cycle();

    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_vec    = $urandom_range(0, 1);
      wb_reg    = 4'($urandom_range(0, 3));
      instr     = enc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                      4'($urandom_range(0, 3))) | 24'($urandom_range(0, 127));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
